// File: rtl/generic_parallel_fir.sv
// Polyphase FIR: P samples per clock, N runtime taps, full-precision per-lane adder trees,
// round-half-up and saturation at the output. Latency 3 + clog2(N) clocks.
module fir_lane #(
  parameter int N = 19,
  parameter int B = 14,
  parameter int F = 17
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                en,
  input  logic [N-1:0][B-1:0] smp,
  input  logic [N-1:0][17:0]  coef,
  output logic [B-1:0]        y
);
  localparam int LVLS = $clog2(N);
  localparam int NP   = 1 << LVLS;
  localparam int AW   = 18 + B + LVLS;
  localparam logic signed [AW:0] RND  = (AW+1)'(1) << (F - 1);
  localparam logic signed [AW:0] YMAX = (AW+1)'((1 << (B - 1)) - 1);
  localparam logic signed [AW:0] YMIN = ~YMAX;

  logic signed [B+17:0] prod [NP];
  logic signed [AW:0]   rnd, shf;

  // Pad the tree to a power of two with constant-zero leaves.
  for (genvar k = 0; k < NP; k++) begin : g_prod
    if (k < N) begin : g_real
      assign prod[k] = $signed(smp[k]) * $signed(coef[k]);
    end else begin : g_pad
      assign prod[k] = '0;
    end
  end

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic signed [AW-1:0] node [NP >> l];
    if (l == 0) begin : g_mul
      always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) for (int i = 0; i < NP; i++) node[i] <= '0;
        else         for (int i = 0; i < NP; i++) node[i] <= AW'(prod[i]);
      end
    end else begin : g_add
      always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) for (int i = 0; i < (NP >> l); i++) node[i] <= '0;
        else for (int i = 0; i < (NP >> l); i++)
          node[i] <= g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign rnd = (AW+1)'(g_lvl[LVLS].node[0]) + RND;
  assign shf = rnd >>> F;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  y <= '0;
    else if (en)  y <= (shf > YMAX) ? B'(YMAX) : (shf < YMIN) ? B'(YMIN) : shf[B-1:0];
  end
endmodule

module generic_parallel_fir #(
  parameter int parallelization = 4,
  parameter int taps            = 19,
  parameter int bits            = 14,
  parameter int CoeffFracBits   = 17
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [bits*parallelization-1:0] x_i,
  input  logic                            valid_i,
  input  logic [18*taps-1:0]              coeff_i,
  output logic [bits*parallelization-1:0] y_out,
  output logic                            valid_o
);
  localparam int P      = parallelization;
  localparam int N      = taps;
  localparam int B      = bits;
  localparam int LVLS   = $clog2(N);
  localparam int HIST   = (N + P - 2) / P;
  localparam int STAGES = 2 + LVLS;

  logic [STAGES:0]              vld_pipe;
  logic [P-1:0][B-1:0]          win [HIST+1];
  logic [N-1:0][17:0]           coef_r;
  logic [(HIST+1)*P-1:0][B-1:0] flat;
  logic [P-1:0][B-1:0]          y_lane;
  logic                         unused_hist;

  // win[0] is the newest word; history only moves on valid words so bubbles vanish.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe <= '0;
      coef_r   <= '0;
      for (int j = 0; j <= HIST; j++) win[j] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], valid_i};
      coef_r   <= coeff_i;
      if (valid_i) begin
        win[0] <= x_i;
        for (int j = 1; j <= HIST; j++) win[j] <= win[j-1];
      end
    end
  end

  // Oldest-first flat sample window; lane m tap k reads sample n-k.
  for (genvar j = 0; j <= HIST; j++) begin : g_flat
    assign flat[(HIST-j)*P +: P] = win[j];
  end
  assign unused_hist = ^flat;

  for (genvar m = 0; m < P; m++) begin : g_lane
    logic [N-1:0][B-1:0] smp;
    for (genvar k = 0; k < N; k++) begin : g_tap
      assign smp[k] = flat[HIST*P + m - k];
    end
    fir_lane #(.N(N), .B(B), .F(CoeffFracBits)) u_lane (
      .gclk   (clk_i),
      .grst_n (rst_n_i),
      .en     (vld_pipe[STAGES-1]),
      .smp    (smp),
      .coef   (coef_r),
      .y      (y_lane[m])
    );
  end

  assign y_out   = y_lane;
  assign valid_o = vld_pipe[STAGES];
endmodule

// File: tb/tb_generic_parallel_fir.sv
// Directed bench for generic_parallel_fir at P=4, N=19, B=14, F=17 (latency 8).
module tb_generic_parallel_fir;
  logic            clk = 0, rst_n = 0, vin = 0;
  logic [55:0]     x = '0;
  logic [18*19-1:0] coeff = '0;
  logic [55:0]     y;
  logic            vo;
  int total = 0, bad = 0;

  int hc[19];
  int hb[19]  = '{69,0,-823,0,3348,0,-10182,0,40345,65558,40345,0,-10182,0,3348,0,-823,0,69};
  int imp[19] = '{2,0,-26,0,105,0,-318,0,1261,2049,1261,0,-318,0,105,0,-26,0,2};
  int stream[$];
  logic vi_log[$], vo_log[$];
  logic [55:0] out_q[$];

  always #5 clk = ~clk;

  generic_parallel_fir #(.parallelization(4), .taps(19), .bits(14), .CoeffFracBits(17)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .x_i(x), .valid_i(vin), .coeff_i(coeff),
    .y_out(y), .valid_o(vo));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int lane(input logic [55:0] w, input int m);
    logic [13:0] s;
    s = w[m*14 +: 14];
    return int'($signed(s));
  endfunction

  function automatic logic [55:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [55:0] w;
    w[13:0] = l0[13:0]; w[27:14] = l1[13:0]; w[41:28] = l2[13:0]; w[55:42] = l3[13:0];
    return w;
  endfunction

  function automatic int model_y(input int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < 19; k++)
      if (n - k >= 0) acc += longint'(hc[k]) * longint'(stream[n-k]);
    acc = (acc + 64'sd65536) >>> 17;
    if (acc > 8191) return 8191;
    if (acc < -8192) return -8192;
    return int'(acc);
  endfunction

  task automatic load_coeffs();
    for (int k = 0; k < 19; k++) coeff[k*18 +: 18] = hc[k][17:0];
  endtask

  task automatic do_reset();
    rst_n = 0; vin = 0; x = '0;
    load_coeffs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    vi_log.delete(); vo_log.delete(); out_q.delete(); stream.delete();
  endtask

  task automatic step(input logic [55:0] xw, input logic v);
    x = xw; vin = v;
    @(posedge clk); #1;
    vi_log.push_back(v);
    vo_log.push_back(vo);
    if (vo) out_q.push_back(y);
  endtask

  task automatic test_reset();
    hc = hb; load_coeffs();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      x = 56'({$urandom(), $urandom()}); vin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      total++;
      if (y !== '0 || vo !== 1'b0) begin
        bad++; $display("FAIL reset_hold cyc%0d: y=%h valid=%b, want 0/0", i, y, vo);
      end
    end
    #2 rst_n = 1;
    for (int i = 0; i < 10; i++) step(56'({$urandom(), $urandom()}), 1'b1);
    total++;
    if (vo !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: valid=%b, want 1", vo); end
    #2 rst_n = 0;
    #1;
    total++;
    if (y !== '0 || vo !== 1'b0) begin
      bad++; $display("FAIL reset_async: y=%h valid=%b, want 0/0", y, vo);
    end
    #1 rst_n = 1;
    total++;
    if (vo !== 1'b0) begin bad++; $display("FAIL release_valid: valid=%b, want 0", vo); end
    for (int s = 0; s < 8; s++) begin
      step(56'({$urandom(), $urandom()}), 1'b1);
      total++;
      if (vo !== (s == 7)) begin
        bad++; $display("FAIL release_lat s%0d: valid=%b, want %0d", s, vo, s == 7);
      end
    end
  endtask

  task automatic test_impulse();
    logic [55:0] w;
    int fv, got, exp;
    hc = hb; do_reset();
    w = '0; w[13:0] = 14'd4096;
    step(w, 1'b1);
    repeat (6) step('0, 1'b1);
    repeat (10) step('0, 1'b0);
    fv = -1;
    for (int i = vo_log.size() - 1; i >= 0; i--) if (vo_log[i]) fv = i;
    total++;
    if (fv != 7) begin bad++; $display("FAIL impulse_latency: first valid at step %0d, want 7", fv); end
    total++;
    if (out_q.size() != 7) begin bad++; $display("FAIL impulse_count: %0d words, want 7", out_q.size()); end
    for (int n = 0; n < 28; n++) begin
      if (n / 4 < out_q.size()) begin
        exp = (n < 19) ? imp[n] : 0;
        got = lane(out_q[n/4], n % 4);
        total++;
        if (got != exp) begin bad++; $display("FAIL impulse_n%0d: got %0d, want %0d", n, got, exp); end
      end
    end
  endtask

  task automatic test_dc(input int val);
    logic [55:0] w;
    hc = hb; do_reset();
    w = pack4(val, val, val, val);
    repeat (12) step(w, 1'b1);
    repeat (10) step('0, 1'b0);
    total++;
    if (out_q.size() != 12) begin bad++; $display("FAIL dc_count %0d: %0d words, want 12", val, out_q.size()); end
    for (int t = 5; t < out_q.size(); t++) begin
      total++;
      if (out_q[t] !== w) begin bad++; $display("FAIL dc_%0d_word%0d: got %h, want %h", val, t, out_q[t], w); end
    end
    total++;
    if (y !== w) begin bad++; $display("FAIL dc_hold %0d: got %h, want %h", val, y, w); end
  endtask

  task automatic test_saturation();
    logic [55:0] e;
    hc = '{default: 0}; hc[0] = 65536; hc[1] = 65536; hc[2] = 65536;
    for (int pass = 0; pass < 2; pass++) begin
      int v;
      v = pass ? -8192 : 8191;
      do_reset();
      repeat (6) step(pack4(v, v, v, v), 1'b1);
      repeat (10) step('0, 1'b0);
      e = pass ? pack4(-4096, -8192, -8192, -8192) : pack4(4096, 8191, 8191, 8191);
      total++;
      if (out_q.size() < 6 || out_q[0] !== e) begin
        bad++; $display("FAIL sat_%0d_word0: got %h, want %h", v, out_q.size() ? out_q[0] : 56'h0, e);
      end
      for (int t = 1; t < out_q.size(); t++) begin
        total++;
        if (out_q[t] !== pack4(v, v, v, v)) begin
          bad++; $display("FAIL sat_%0d_word%0d: got %h, want %h", v, t, out_q[t], pack4(v, v, v, v));
        end
      end
    end
    do_reset();
    step(pack4(3, -3, 0, 0), 1'b1);
    repeat (10) step('0, 1'b0);
    e = pack4(2, 0, 0, -1);
    total++;
    if (out_q.size() < 1 || out_q[0] !== e) begin
      bad++; $display("FAIL round_half_up: got %h, want %h", out_q.size() ? out_q[0] : 56'h0, e);
    end
  endtask

  task automatic test_valid_gaps();
    logic [55:0] w, e;
    int n, cyc, vm, s;
    hc = hb; do_reset();
    n = 0; cyc = 0;
    while (n < 250 && cyc < 3000) begin
      cyc++;
      if ($urandom_range(0, 3) != 0) begin
        for (int m = 0; m < 4; m++) begin
          int idx;
          idx = 4 * n + m;
          s = $rtoi(3000.0 * $sin(0.3 * real'(idx)) + 2500.0 * $sin(2.1 * real'(idx) + 0.5));
          stream.push_back(s);
          w[m*14 +: 14] = s[13:0];
        end
        step(w, 1'b1);
        n++;
      end else begin
        step(56'({$urandom(), $urandom()}), 1'b0);
      end
    end
    repeat (10) step('0, 1'b0);
    total++;
    if (out_q.size() != 250) begin bad++; $display("FAIL gap_count: %0d words, want 250", out_q.size()); end
    for (int t = 0; t < out_q.size() && t < 250; t++) begin
      e = pack4(model_y(4*t), model_y(4*t+1), model_y(4*t+2), model_y(4*t+3));
      total++;
      if (out_q[t] !== e) begin bad++; $display("FAIL gap_word%0d: got %h, want %h", t, out_q[t], e); end
    end
    vm = 0;
    for (int i = 0; i < 7; i++) if (vo_log[i] !== 1'b0) vm++;
    for (int i = 0; i + 7 < vo_log.size(); i++) if (vo_log[i+7] !== vi_log[i]) vm++;
    total++;
    if (vm != 0) begin bad++; $display("FAIL gap_valid_pattern: %0d cycles differ, want 0", vm); end
  endtask

  task automatic test_lane_order();
    logic [55:0] w;
    int got, exp;
    hc = hb;
    for (int m = 0; m < 4; m++) begin
      do_reset();
      w = '0; w[m*14 +: 14] = 14'd4096;
      step(w, 1'b1);
      repeat (6) step('0, 1'b1);
      repeat (10) step('0, 1'b0);
      total++;
      if (out_q.size() != 7) begin bad++; $display("FAIL lane%0d_count: %0d words, want 7", m, out_q.size()); end
      for (int n = 0; n < 28; n++) begin
        if (n / 4 < out_q.size()) begin
          exp = (n >= m && n - m < 19) ? imp[n-m] : 0;
          got = lane(out_q[n/4], n % 4);
          total++;
          if (got != exp) begin bad++; $display("FAIL lane%0d_n%0d: got %0d, want %0d", m, n, got, exp); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc(4096);
    test_dc(-8192);
    test_saturation();
    test_valid_gaps();
    test_lane_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
